// File: rtl/emu_pkg.sv
// Shared types and pong_pt1 defaults for the emulator host sequencer.
package emu_pkg;

    localparam int NUM_STIM_DEF = 1;
    localparam int NUM_OUT_DEF  = 2;
    localparam int ADDR_W_DEF   = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        WSETTLE,
        LOAD,
        CLK_HI,
        CLK_LO,
        GET,
        RD_ADDR,
        RD_WAIT,
        RD_SEND
    } state_t;

endpackage

// File: rtl/emu_host_sequencer_clk_gen.sv
// One-shot DUT clock generator: high for CLK_HI_CYC, low for CLK_LO_CYC cycles.
module emu_clk_gen #(
    parameter int CLK_HI_CYC = 2,
    parameter int CLK_LO_CYC = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic clk_dut,
    output logic fall,
    output logic done
);
    localparam int MAX_CYC = (CLK_HI_CYC > CLK_LO_CYC) ? CLK_HI_CYC : CLK_LO_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(CLK_HI_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(CLK_LO_CYC - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_HI, PH_LO} phase_t;

    phase_t           phase, phase_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             clk_dut_d;

    // fall/done flag the last cycle of each phase so the sequencer steps on the same edge
    assign fall = (phase == PH_HI) && (cnt == HI_LAST);
    assign done = (phase == PH_LO) && (cnt == LO_LAST);

    always_comb begin
        phase_d   = phase;
        cnt_d     = cnt;
        clk_dut_d = clk_dut;
        case (phase)
            PH_IDLE: if (start) begin
                phase_d   = PH_HI;
                cnt_d     = '0;
                clk_dut_d = 1'b1;
            end
            PH_HI: if (fall) begin
                phase_d   = PH_LO;
                cnt_d     = '0;
                clk_dut_d = 1'b0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
            PH_LO: if (done) phase_d = PH_IDLE;
                   else      cnt_d   = cnt + CNT_W'(1);
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= PH_IDLE;
            cnt     <= '0;
            clk_dut <= 1'b0;
        end else begin
            phase   <= phase_d;
            cnt     <= cnt_d;
            clk_dut <= clk_dut_d;
        end
    end

endmodule

// File: rtl/emu_host_sequencer.sv
// Host-side transactor for the co-emulation wrapper: writes stimulus bytes,
// steps the DUT clock once, then streams the captured output bytes back.
module emu_host_sequencer
    import emu_pkg::*;
#(
    parameter int NUM_STIM   = NUM_STIM_DEF,
    parameter int NUM_OUT    = NUM_OUT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CLK_HI_CYC = 2,
    parameter int CLK_LO_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        Din_emu,
    output logic [ADDR_W-1:0] Addr_emu,
    input  logic [7:0]        Dout_emu,
    output logic              load_emu,
    output logic              get_emu,
    output logic              clk_dut,
    output logic              busy,
    output logic [15:0]       vec_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_STIM = ADDR_W'(NUM_STIM - 1);
    localparam logic [ADDR_W-1:0] LAST_OUT  = ADDR_W'(NUM_OUT - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d, jdx, jdx_d, jdx_inc, addr_d;
    byte_t             din_d, m_data_d;
    byte_t             shadow [DEPTH];
    logic              s_ready_d, m_valid_d, load_d, get_d, busy_d;
    logic [15:0]       vec_count_d;
    logic              accept, clk_start, clk_fall, clk_done;

    assign accept  = s_valid && s_ready;
    assign jdx_inc = jdx + ADDR_W'(1);

    emu_clk_gen #(
        .CLK_HI_CYC (CLK_HI_CYC),
        .CLK_LO_CYC (CLK_LO_CYC)
    ) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (clk_start),
        .clk_dut (clk_dut),
        .fall    (clk_fall),
        .done    (clk_done)
    );

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        jdx_d       = jdx;
        addr_d      = Addr_emu;
        din_d       = Din_emu;
        m_data_d    = m_data;
        m_valid_d   = m_valid;
        load_d      = 1'b0;
        get_d       = 1'b0;
        vec_count_d = vec_count;
        clk_start   = 1'b0;
        case (state)
            IDLE, WR: if (accept) begin
                din_d  = s_data;
                addr_d = idx;
                if (idx == LAST_STIM) begin
                    idx_d   = '0;
                    state_d = WSETTLE;
                end else begin
                    idx_d   = idx + ADDR_W'(1);
                    state_d = WR;
                end
            end
            WSETTLE: begin
                load_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                clk_start = 1'b1;
                state_d   = CLK_HI;
            end
            CLK_HI: if (clk_fall) state_d = CLK_LO;
            CLK_LO: if (clk_done) begin
                get_d   = 1'b1;
                state_d = GET;
            end
            // Din follows shadow[Addr] during readback so the wrapper's
            // free-running stimulus write never corrupts a stimulus byte.
            GET: begin
                jdx_d   = '0;
                addr_d  = '0;
                din_d   = shadow[0];
                state_d = RD_ADDR;
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                m_data_d  = Dout_emu;
                m_valid_d = 1'b1;
                state_d   = RD_SEND;
            end
            RD_SEND: if (m_ready) begin
                m_valid_d = 1'b0;
                if (jdx != LAST_OUT) begin
                    jdx_d   = jdx_inc;
                    addr_d  = jdx_inc;
                    din_d   = shadow[jdx_inc];
                    state_d = RD_ADDR;
                end else begin
                    vec_count_d = vec_count + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == IDLE) || (state_d == WR);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            jdx       <= '0;
            Addr_emu  <= '0;
            Din_emu   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            s_ready   <= 1'b0;
            load_emu  <= 1'b0;
            get_emu   <= 1'b0;
            busy      <= 1'b0;
            vec_count <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            jdx       <= jdx_d;
            Addr_emu  <= addr_d;
            Din_emu   <= din_d;
            m_data    <= m_data_d;
            m_valid   <= m_valid_d;
            s_ready   <= s_ready_d;
            load_emu  <= load_d;
            get_emu   <= get_d;
            busy      <= busy_d;
            vec_count <= vec_count_d;
        end
    end

    // NOTE: the shadow array is reset on purpose: entries at or above NUM_STIM are
    // never written, so they stay zero and drive Din_emu=0 for those addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) shadow[k] <= '0;
        end else if (accept) begin
            shadow[idx] <= s_data;
        end
    end

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Self-checking bench: two sequencer instances, each driving a behavioural wrapper/DUT model.
module tb_emu_host_sequencer;

    localparam int HI_A = 2, LO_A = 2;
    localparam int LOAD_K = 1, RISE_K = 2;
    localparam int FALL_K = RISE_K + HI_A, GET_K = FALL_K + LO_A;
    localparam int MV_K   = GET_K + 3, MV2_K = MV_K + 3;
    localparam int HI_B = 1, LO_B = 3;
    localparam int FALL_B = RISE_K + HI_B, GET_B = FALL_B + LO_B, MV_B = GET_B + 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  s_data_a = '0, m_data_a, din_a, dout_a = '0;
    logic        s_valid_a = 1'b0, s_ready_a, m_valid_a, m_ready_a = 1'b0;
    logic [2:0]  addr_a;
    logic        load_a, get_a, clk_dut_a, busy_a;
    logic [15:0] vec_count_a;

    logic [7:0]  s_data_b = '0, m_data_b, din_b, dout_b = '0;
    logic        s_valid_b = 1'b0, s_ready_b, m_valid_b, m_ready_b = 1'b0;
    logic [2:0]  addr_b;
    logic        load_b, get_b, clk_dut_b, busy_b;
    logic [15:0] vec_count_b;

    emu_host_sequencer dut_a (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .Din_emu(din_a), .Addr_emu(addr_a), .Dout_emu(dout_a),
        .load_emu(load_a), .get_emu(get_a), .clk_dut(clk_dut_a),
        .busy(busy_a), .vec_count(vec_count_a)
    );

    emu_host_sequencer #(
        .NUM_STIM(3), .NUM_OUT(1), .ADDR_W(3), .CLK_HI_CYC(HI_B), .CLK_LO_CYC(LO_B)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .Din_emu(din_b), .Addr_emu(addr_b), .Dout_emu(dout_b),
        .load_emu(load_b), .get_emu(get_b), .clk_dut(clk_dut_b),
        .busy(busy_b), .vec_count(vec_count_b)
    );

    // Wrapper models: free-running stimulus write, apply on load, evaluate on a
    // clk_dut rising edge, capture on get, registered readback.
    logic [7:0] stim_a [8], applied_a [8], dut_out_a [8], cap_a [8];
    logic [7:0] stim_b [8], applied_b [8], dut_out_b [8], cap_b [8];
    logic       ck_prev_a = 1'b0, ck_prev_b = 1'b0;

    always @(posedge clk) begin
        if (!load_a && !get_a) stim_a[addr_a] <= din_a;
        if (load_a) applied_a <= stim_a;
        ck_prev_a <= clk_dut_a;
        if (clk_dut_a && !ck_prev_a) begin
            dut_out_a[0] <= applied_a[0];
            dut_out_a[1] <= ~applied_a[0];
        end
        if (get_a) cap_a <= dut_out_a;
        dout_a <= cap_a[addr_a];
    end

    always @(posedge clk) begin
        if (!load_b && !get_b) stim_b[addr_b] <= din_b;
        if (load_b) applied_b <= stim_b;
        ck_prev_b <= clk_dut_b;
        if (clk_dut_b && !ck_prev_b) dut_out_b[0] <= applied_b[0] + applied_b[1] + applied_b[2];
        if (get_b) cap_b <= dut_out_b;
        dout_b <= cap_b[addr_b];
    end

    int n_tests = 0, n_fail = 0;
    logic [15:0] exp_vc_a = '0, exp_vc_b = '0;
    logic [7:0] rx_a [$];
    int stab_err, rdy_err;

    function automatic logic [7:0] model_a(input logic [7:0] s, input int j);
        return (j == 0) ? s : ~s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        bit ok, hs;
        ok = 1'b0;
        s_data_a = b;
        s_valid_a = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            hs = s_ready_a;
            tick();
            ok = hs;
        end
        s_valid_a = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL send_a_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        bit ok, hs;
        ok = 1'b0;
        s_data_b = b;
        s_valid_b = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            hs = s_ready_b;
            tick();
            ok = hs;
        end
        s_valid_b = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL send_b_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic collect_a(input int n, input bit rand_ready, input int budget);
        logic       v, r;
        logic [7:0] d;
        rx_a.delete();
        stab_err = 0;
        rdy_err  = 0;
        for (int t = 0; t < budget && rx_a.size() < n; t++) begin
            m_ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid_a && m_ready_a) rx_a.push_back(m_data_a);
            v = m_valid_a; d = m_data_a; r = m_ready_a;
            tick();
            if (v && !r && (!m_valid_a || m_data_a !== d)) stab_err++;
            if (s_ready_a && busy_a) rdy_err++;
        end
        m_ready_a = 1'b0;
        if (rx_a.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL collect_a_timeout: got %0d bytes want %0d", rx_a.size(), n);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick();
        n_tests++;
        if ({s_ready_a, m_valid_a, m_data_a, din_a, addr_a, load_a, get_a, clk_dut_a, busy_a, vec_count_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got %h want 0",
                     {s_ready_a, m_valid_a, m_data_a, din_a, addr_a, load_a, get_a, clk_dut_a, busy_a, vec_count_a});
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({s_ready_a, busy_a, s_ready_b, busy_b} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 1010", {s_ready_a, busy_a, s_ready_b, busy_b});
        end
    endtask

    task automatic test_latency();
        logic [16:0] ld, ck, gt, mv, e_ld, e_ck, e_gt, e_mv;
        logic [7:0]  md [17], dn [17];
        logic [2:0]  ad [17];
        m_ready_a = 1'b1;
        send_a(8'h0A);
        for (int k = 0; k < 17; k++) begin
            if (k > 0) tick();
            ld[k] = load_a; ck[k] = clk_dut_a; gt[k] = get_a; mv[k] = m_valid_a;
            md[k] = m_data_a; dn[k] = din_a; ad[k] = addr_a;
        end
        m_ready_a = 1'b0;
        exp_vc_a++;
        e_ld = '0; e_ck = '0; e_gt = '0; e_mv = '0;
        e_ld[LOAD_K] = 1'b1;
        for (int k = RISE_K; k < FALL_K; k++) e_ck[k] = 1'b1;
        e_gt[GET_K] = 1'b1;
        e_mv[MV_K] = 1'b1;
        e_mv[MV2_K] = 1'b1;
        n_tests++;
        if ({dn[0], ad[0], dn[1], ad[1]} !== {8'h0A, 3'd0, 8'h0A, 3'd0}) begin
            n_fail++;
            $display("FAIL write_din_addr: got %h/%0d %h/%0d want 0a/0 0a/0", dn[0], ad[0], dn[1], ad[1]);
        end
        n_tests++;
        if (ld !== e_ld) begin n_fail++; $display("FAIL load_pulse: got %b want %b", ld, e_ld); end
        n_tests++;
        if (ck !== e_ck) begin n_fail++; $display("FAIL clk_dut_shape: got %b want %b", ck, e_ck); end
        n_tests++;
        if (gt !== e_gt) begin n_fail++; $display("FAIL get_pulse: got %b want %b", gt, e_gt); end
        n_tests++;
        if (mv !== e_mv) begin n_fail++; $display("FAIL m_valid_timing: got %b want %b", mv, e_mv); end
        n_tests++;
        if ({md[MV_K], md[MV2_K]} !== {model_a(8'h0A, 0), model_a(8'h0A, 1)}) begin
            n_fail++;
            $display("FAIL readback_data: got %h %h want %h %h", md[MV_K], md[MV2_K], model_a(8'h0A, 0), model_a(8'h0A, 1));
        end
        n_tests++;
        if ({ad[MV2_K], dn[MV2_K]} !== {3'd1, 8'h00}) begin
            n_fail++;
            $display("FAIL din_above_num_stim: got addr %0d din %h want addr 1 din 00", ad[MV2_K], dn[MV2_K]);
        end
        n_tests++;
        if ({busy_a, vec_count_a, stim_a[0]} !== {1'b0, exp_vc_a, 8'h0A}) begin
            n_fail++;
            $display("FAIL latency_end: got busy %b cnt %0d stim %h want 0 %0d 0a", busy_a, vec_count_a, stim_a[0], exp_vc_a);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s, d2;
        logic [2:0] vv;
        bit         seen;
        int         bad;
        s = 8'($urandom);
        m_ready_a = 1'b0;
        send_a(s);
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin tick(); seen = m_valid_a; end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL bp_first_valid: m_valid never rose within 30 cycles"); end
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (!m_valid_a || m_data_a !== s || clk_dut_a) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles, want 0 (data %h)", bad, s); end
        m_ready_a = 1'b1;
        tick(); vv[2] = m_valid_a;
        tick(); vv[1] = m_valid_a;
        tick(); vv[0] = m_valid_a; d2 = m_data_a;
        tick();
        m_ready_a = 1'b0;
        exp_vc_a++;
        n_tests++;
        if ({vv, d2} !== {3'b001, model_a(s, 1)}) begin
            n_fail++;
            $display("FAIL bp_release: got valid %b data %h want 001 %h", vv, d2, model_a(s, 1));
        end
        n_tests++;
        if ({busy_a, vec_count_a} !== {1'b0, exp_vc_a}) begin
            n_fail++;
            $display("FAIL bp_count: got busy %b cnt %0d want 0 %0d", busy_a, vec_count_a, exp_vc_a);
        end
    endtask

    task automatic run_vectors(input int nv, input bit fixed, input bit rand_ready);
        logic [7:0] sent [$];
        fork
            for (int v = 0; v < nv; v++) begin
                logic [7:0] b;
                b = fixed ? 8'(v + 1) : 8'($urandom);
                sent.push_back(b);
                send_a(b);
            end
            collect_a(2 * nv, rand_ready, 200 * nv);
        join
        exp_vc_a += 16'(nv);
        for (int v = 0; v < nv; v++) begin
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (rx_a[2 * v + j] !== model_a(sent[v], j)) begin
                    n_fail++;
                    $display("FAIL stream_byte[%0d]: got %h want %h", 2 * v + j, rx_a[2 * v + j], model_a(sent[v], j));
                end
            end
        end
        n_tests++;
        if ({stab_err, rdy_err} != 64'd0) begin
            n_fail++;
            $display("FAIL stream_protocol: unstable %0d s_ready-while-busy %0d want 0 0", stab_err, rdy_err);
        end
        n_tests++;
        if (vec_count_a !== exp_vc_a) begin
            n_fail++;
            $display("FAIL stream_count: got %0d want %0d", vec_count_a, exp_vc_a);
        end
    endtask

    task automatic test_back_to_back();
        run_vectors(4, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        run_vectors(8, 1'b0, 1'b1);
    endtask

    task automatic test_params();
        logic [14:0] ld, ck, gt, mv, e_ld, e_ck, e_gt, e_mv;
        logic [23:0] stim_at_load;
        logic [7:0]  first;
        m_ready_b = 1'b1;
        send_b(8'h11);
        send_b(8'h22);
        send_b(8'h33);
        first = '0;
        stim_at_load = '0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            ld[k] = load_b; ck[k] = clk_dut_b; gt[k] = get_b; mv[k] = m_valid_b;
            if (k == LOAD_K) stim_at_load = {stim_b[0], stim_b[1], stim_b[2]};
            if (k == MV_B) first = m_data_b;
        end
        m_ready_b = 1'b0;
        exp_vc_b++;
        e_ld = '0; e_ck = '0; e_gt = '0; e_mv = '0;
        e_ld[LOAD_K] = 1'b1;
        for (int k = RISE_K; k < FALL_B; k++) e_ck[k] = 1'b1;
        e_gt[GET_B] = 1'b1;
        e_mv[MV_B] = 1'b1;
        n_tests++;
        if (stim_at_load !== 24'h112233) begin
            n_fail++; $display("FAIL p_stim_at_load: got %h want 112233", stim_at_load);
        end
        n_tests++;
        if ({ld, ck, gt, mv} !== {e_ld, e_ck, e_gt, e_mv}) begin
            n_fail++;
            $display("FAIL p_timing: got ld %b ck %b gt %b mv %b want %b %b %b %b", ld, ck, gt, mv, e_ld, e_ck, e_gt, e_mv);
        end
        n_tests++;
        if (first !== 8'(8'h11 + 8'h22 + 8'h33)) begin
            n_fail++; $display("FAIL p_readback: got %h want 66", first);
        end
        n_tests++;
        if ({stim_b[0], stim_b[1], stim_b[2], vec_count_b, busy_b} !== {24'h112233, exp_vc_b, 1'b0}) begin
            n_fail++;
            $display("FAIL p_after: got stim %h%h%h cnt %0d busy %b want 112233 %0d 0",
                     stim_b[0], stim_b[1], stim_b[2], vec_count_b, busy_b, exp_vc_b);
        end
    endtask

    task automatic test_reset_midvector();
        bit seen;
        m_ready_a = 1'b1;
        send_a(8'h3C);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = clk_dut_a; end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rst_reach_clk_hi: clk_dut never rose within 10 cycles"); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({clk_dut_a, load_a, get_a, m_valid_a, busy_a, vec_count_a, s_ready_a, addr_a, din_a} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0",
                     {clk_dut_a, load_a, get_a, m_valid_a, busy_a, vec_count_a, s_ready_a, addr_a, din_a});
        end
        tick();
        tick();
        reset_n = 1'b1;
        exp_vc_a = '0;
        exp_vc_b = '0;
        tick();
        send_a(8'h55);
        collect_a(2, 1'b0, 100);
        exp_vc_a++;
        n_tests++;
        if ({rx_a[0], rx_a[1], vec_count_a} !== {model_a(8'h55, 0), model_a(8'h55, 1), exp_vc_a}) begin
            n_fail++;
            $display("FAIL rst_recover: got %h %h cnt %0d want 55 aa %0d", rx_a[0], rx_a[1], vec_count_a, exp_vc_a);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s;
        s = 8'($urandom);
        force dut_a.vec_count = 16'hFFFF;
        #1;
        release dut_a.vec_count;
        exp_vc_a = 16'hFFFF;
        send_a(s);
        collect_a(2, 1'b0, 100);
        exp_vc_a++;
        n_tests++;
        if ({rx_a[0], rx_a[1], vec_count_a} !== {model_a(s, 0), model_a(s, 1), exp_vc_a}) begin
            n_fail++;
            $display("FAIL count_wrap: got %h %h cnt %h want %h %h %h",
                     rx_a[0], rx_a[1], vec_count_a, model_a(s, 0), model_a(s, 1), exp_vc_a);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_params();
        test_reset_midvector();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
